mem_stage_lsu: RTL and testbench
================================

Name: mem_stage_lsu

Overview:
- Memory stage of the 5-stage RV32 pipeline; consumes EX/MEM register outputs and drives the data-memory bus through a req/ready handshake.
- Performs store byte-lane steering, load extraction and extension, and misalignment and access-fault detection.
- Stalls upstream while a bus access is in flight, then writes the selected result into an internal MEM/WB register.

Parameters:
- TIMEOUT_CYCLES, 64: bus cycles in BUSY before a forced access fault; used only with the optional feature.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_clk_en  in  1  MEM/WB update and launch enable from the hazard unit
- i_rd_m  in  5  destination register
- i_alu_out_m  in  32  ALU result / effective address
- i_haz_b_m  in  32  store data
- i_pc_p4_m  in  32  PC+4
- i_reg_wr_m  in  1  register write
- i_result_src_m  in  2  00 ALU, 01 load, 10 PC+4
- i_mem_write_m  in  1  store
- i_f3_m  in  3  funct3 (size/sign)
- o_dmem_req  out  1  bus request
- o_dmem_we  out  1  bus write
- o_dmem_addr  out  32  word-aligned address
- o_dmem_wdata  out  32  lane-steered write data
- o_dmem_be  out  4  byte enables
- i_dmem_ready  in  1  bus completion
- i_dmem_rdata  in  32  read word
- i_dmem_err  in  1  bus error, qualified by ready
- o_stall_m  out  1  hold IF/ID/EX/MEM
- o_exception_code_m  out  4  4'b1111 means none
- o_bad_addr_m  out  32  faulting address
- o_rd_w  out  5  MEM/WB destination register
- o_result_w  out  32  MEM/WB writeback value
- o_reg_wr_w  out  1  MEM/WB write enable

Behaviour:
- Clock and reset:
  - One clock, i_clk. Reset i_rst is synchronous and active-high.
  - Reset: state IDLE; MEM/WB outputs 0; o_dmem_* 0; o_stall_m 0; o_exception_code_m 4'b1111; o_bad_addr_m 0.
  - Reset while in BUSY abandons the access; o_dmem_req is low from the next cycle, and the memory must tolerate the abandoned request.
- Operation classes:
  - mem_op = i_mem_write_m | (i_result_src_m==01).
  - Non-memory op: MEM/WB loads rd, reg_wr and result (ALU or PC+4) on an edge with i_clk_en=1. Latency 1, no stall.
- FSM IDLE -> BUSY -> IDLE:
  - IDLE with mem_op, legal f3, aligned address and i_clk_en=1: registers the bus fields and enters BUSY.
  - In BUSY, o_dmem_req=1; addr, we, be and wdata are held stable until the edge where req & ready.
  - That edge writes MEM/WB and returns the FSM to IDLE.
  - Minimum memory-op latency is 2 cycles.
  - i_clk_en is ignored in BUSY; the hazard unit drops it only while the FSM is in IDLE.
- Stall: o_stall_m = mem_op & !(BUSY & i_dmem_ready), combinational. It deasserts in the completion cycle so EX/MEM advances at the same edge; no reissue.
- Store steering:
  - sb: be = 1 << addr[1:0]; byte replicated ×4.
  - sh: be = 0011 << (2·addr[1]); halfword replicated ×2.
  - sw: be = 1111.
  - o_dmem_addr = {addr[31:2], 2'b00}.
- Load extraction: lb/lbu take the byte at addr[1:0]; lh/lhu take the halfword at addr[1]; lb/lh sign-extend; lbu/lhu zero-extend; lw passes the word through.
- Exceptions: single-cycle combinational code, no bus request; MEM/WB loads a bubble (reg_wr=0, rd=0); o_bad_addr_m = i_alu_out_m.
  - Halfword with addr[0]=1, or word with addr[1:0]≠0: code 4 for a load, 6 for a store.
  - f3 ∈ {011,110,111}, or a store with f3 in {100,101}: code 2.
  - Completion with i_dmem_err=1: code 5 for a load, 7 for a store, in the completion cycle.
  - Exception and completion never coincide with a new launch.
- Back-to-back memory ops: the second launches in the cycle after the first completes.

Optional Feature:
- Macro MEM_STAGE_LSU_TIMEOUT_EN.
- Defined: an 8-bit-or-wider counter clears on BUSY entry and increments each BUSY cycle without ready. On reaching TIMEOUT_CYCLES it forces completion as an access fault (code 5/7), drops req, returns to IDLE and loads a MEM/WB bubble.
- Undefined: no counter; BUSY waits indefinitely.

Decomposition:
- Package lsu_pkg holds:
  - state encoding: IDLE, BUSY
  - exception constants: EXC_NONE=4'hF, EXC_ILLEGAL=2, EXC_LD_MISALIGN=4, EXC_LD_FAULT=5, EXC_ST_MISALIGN=6, EXC_ST_FAULT=7
  - funct3 constants: F3_B, F3_H, F3_W, F3_BU, F3_HU
  - result-source constants: RS_ALU, RS_LOAD, RS_PC4
- One combinational sub-module, lsu_load_align: inputs rdata, addr[1:0], f3; output extended 32-bit value.

Test Plan:
- sw addr 0x104, data 0xDEADBEEF; ready on the first BUSY cycle -> be=1111, addr 0x104, stall high for 1 cycle, reg_wr_w=0.
- lb addr 0x203, rdata 0x80FF_0000 -> be irrelevant, result_w 0xFFFFFF80; lbu at the same address -> 0x00000080.
- sh addr 0x301, data 0x1234 -> no req, exception 6, bad_addr 0x301, MEM/WB bubble, exception 4'hF the following cycle.
- lw with ready delayed 3 cycles -> req and addr stable for 4 cycles, stall high for 4 cycles, result written on the completion edge.
- lw completing with err=1 -> exception 5, reg_wr_w=0.
- Reset asserted in BUSY -> req=0 and stall=0 next cycle; with the macro defined, no ready for 64 cycles -> exception 5.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared encodings and lane-enable helper for the memory-stage load/store unit
package lsu_pkg;
  typedef enum logic {IDLE, BUSY} state_t;
  localparam logic [3:0] EXC_NONE = 4'hF;
  localparam logic [3:0] EXC_ILLEGAL = 4'd2;
  localparam logic [3:0] EXC_LD_MISALIGN = 4'd4;
  localparam logic [3:0] EXC_LD_FAULT = 4'd5;
  localparam logic [3:0] EXC_ST_MISALIGN = 4'd6;
  localparam logic [3:0] EXC_ST_FAULT = 4'd7;
  localparam logic [2:0] F3_B = 3'b000;
  localparam logic [2:0] F3_H = 3'b001;
  localparam logic [2:0] F3_W = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [1:0] RS_ALU = 2'b00;
  localparam logic [1:0] RS_LOAD = 2'b01;
  localparam logic [1:0] RS_PC4 = 2'b10;
  function automatic logic [3:0] lane_en(input logic [2:0] f3, input logic [1:0] a);
    return f3[1:0] == F3_B[1:0] ? 4'b0001 << a : f3[1:0] == F3_H[1:0] ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  endfunction
endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: picks the addressed byte/halfword of a read word and sign- or zero-extends it
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  f3,
  output logic [31:0] value
);
  logic [15:0] h;
  logic [7:0] b;
  assign h = addr[1] ? rdata[31:16] : rdata[15:0];
  assign b = addr[0] ? h[15:8] : h[7:0];
  always_comb value = f3 == F3_B ? {{24{b[7]}}, b} : f3 == F3_BU ? {24'h0, b} :
                      f3 == F3_H ? {{16{h[15]}}, h} : f3 == F3_HU ? {16'h0, h} : rdata;
endmodule

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: RV32 memory stage with req/ready data bus; MEM_STAGE_LSU_TIMEOUT_EN adds a bus timeout fault
module mem_stage_lsu
  import lsu_pkg::*;
`ifdef MEM_STAGE_LSU_TIMEOUT_EN
  #(parameter int TIMEOUT_CYCLES = 64)
`endif
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_clk_en,
  input  logic [4:0]  i_rd_m,
  input  logic [31:0] i_alu_out_m,
  input  logic [31:0] i_haz_b_m,
  input  logic [31:0] i_pc_p4_m,
  input  logic        i_reg_wr_m,
  input  logic [1:0]  i_result_src_m,
  input  logic        i_mem_write_m,
  input  logic [2:0]  i_f3_m,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  output logic [31:0] o_dmem_addr,
  output logic [31:0] o_dmem_wdata,
  output logic [3:0]  o_dmem_be,
  input  logic        i_dmem_ready,
  input  logic [31:0] i_dmem_rdata,
  input  logic        i_dmem_err,
  output logic        o_stall_m,
  output logic [3:0]  o_exception_code_m,
  output logic [31:0] o_bad_addr_m,
  output logic [4:0]  o_rd_w,
  output logic [31:0] o_result_w,
  output logic        o_reg_wr_w
);
  state_t state;
  logic [31:0] addr_q, wdata, load_val;
  logic [4:0] rd_q;
  logic [2:0] f3_q;
  logic reg_wr_q, mem_op, illegal, misal, exc_id, launch, tmo, done, fault, wr_ok;
  assign mem_op = i_mem_write_m | (i_result_src_m == RS_LOAD);
  assign illegal = (i_f3_m inside {3'b011, 3'b110, 3'b111}) | (i_mem_write_m & i_f3_m[2]);
  assign misal = (i_f3_m[1:0] == F3_H[1:0] & i_alu_out_m[0]) | (i_f3_m[1:0] == F3_W[1:0] & |i_alu_out_m[1:0]);
  assign exc_id = state == IDLE & mem_op & (illegal | misal);
  assign launch = state == IDLE & mem_op & !exc_id & i_clk_en;
  assign done = state == BUSY & (i_dmem_ready | tmo);
  assign fault = state == BUSY & ((i_dmem_ready & i_dmem_err) | tmo);
  assign wr_ok = !fault & !o_dmem_we;
  assign wdata = i_f3_m[1:0] == F3_B[1:0] ? {4{i_haz_b_m[7:0]}} :
                 i_f3_m[1:0] == F3_H[1:0] ? {2{i_haz_b_m[15:0]}} : i_haz_b_m;
  assign o_dmem_req = state == BUSY;
  assign o_stall_m = !i_rst & mem_op & !exc_id & !done;
  assign o_exception_code_m = i_rst ? EXC_NONE :
                              fault ? (o_dmem_we ? EXC_ST_FAULT : EXC_LD_FAULT) :
                              exc_id ? (illegal ? EXC_ILLEGAL : i_mem_write_m ? EXC_ST_MISALIGN : EXC_LD_MISALIGN) :
                              EXC_NONE;
  assign o_bad_addr_m = i_rst ? '0 : fault ? addr_q : exc_id ? i_alu_out_m : '0;
  lsu_load_align u_align (.rdata(i_dmem_rdata), .addr(addr_q[1:0]), .f3(f3_q), .value(load_val));
`ifdef MEM_STAGE_LSU_TIMEOUT_EN
  logic [15:0] cnt;
  assign tmo = state == BUSY & !i_dmem_ready & cnt == 16'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge i_clk)
    if (i_rst || launch) cnt <= '0;
    else if (state == BUSY && !i_dmem_ready) cnt <= cnt + 16'd1;
`else
  assign tmo = 1'b0;
`endif
  always_ff @(posedge i_clk)
    if (i_rst) begin
      state <= IDLE;
      o_dmem_we <= 1'b0;
      o_dmem_addr <= '0;
      o_dmem_wdata <= '0;
      o_dmem_be <= '0;
      addr_q <= '0;
      rd_q <= '0;
      f3_q <= '0;
      reg_wr_q <= 1'b0;
      o_rd_w <= '0;
      o_result_w <= '0;
      o_reg_wr_w <= 1'b0;
    end else if (state == BUSY) begin
      if (done) begin
        state <= IDLE;
        o_rd_w <= wr_ok ? rd_q : '0;
        o_reg_wr_w <= wr_ok & reg_wr_q;
        o_result_w <= wr_ok ? load_val : '0;
      end
    end else if (i_clk_en) begin
      o_rd_w <= mem_op ? '0 : i_rd_m;
      o_reg_wr_w <= !mem_op & i_reg_wr_m;
      o_result_w <= mem_op ? '0 : i_result_src_m == RS_ALU ? i_alu_out_m : i_result_src_m == RS_PC4 ? i_pc_p4_m : '0;
      if (launch) begin
        state <= BUSY;
        o_dmem_we <= i_mem_write_m;
        o_dmem_addr <= {i_alu_out_m[31:2], 2'b00};
        o_dmem_be <= lane_en(i_f3_m, i_alu_out_m[1:0]);
        o_dmem_wdata <= wdata;
        addr_q <= i_alu_out_m;
        rd_q <= i_rd_m;
        f3_q <= i_f3_m;
        reg_wr_q <= i_reg_wr_m;
      end
    end
endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: scoreboard bench for mem_stage_lsu
module tb_mem_stage_lsu;
  localparam int TMO = 64;
  logic clk = 0, rst = 1, clk_en = 1;
  logic [4:0] rd_m;
  logic [31:0] alu_m, data_m, pc4_m;
  logic reg_wr_m, mem_write_m;
  logic [1:0] rs_m;
  logic [2:0] f3_m;
  logic dmem_req, dmem_we, dmem_ready, dmem_err, stall;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata, bad_addr, result_w;
  logic [3:0] dmem_be, exc;
  logic [4:0] rd_w;
  logic reg_wr_w;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  mem_stage_lsu dut (
    .i_clk(clk), .i_rst(rst), .i_clk_en(clk_en), .i_rd_m(rd_m), .i_alu_out_m(alu_m),
    .i_haz_b_m(data_m), .i_pc_p4_m(pc4_m), .i_reg_wr_m(reg_wr_m), .i_result_src_m(rs_m),
    .i_mem_write_m(mem_write_m), .i_f3_m(f3_m), .o_dmem_req(dmem_req), .o_dmem_we(dmem_we),
    .o_dmem_addr(dmem_addr), .o_dmem_wdata(dmem_wdata), .o_dmem_be(dmem_be),
    .i_dmem_ready(dmem_ready), .i_dmem_rdata(dmem_rdata), .i_dmem_err(dmem_err),
    .o_stall_m(stall), .o_exception_code_m(exc), .o_bad_addr_m(bad_addr),
    .o_rd_w(rd_w), .o_result_w(result_w), .o_reg_wr_w(reg_wr_w)
  );

  typedef struct {
    string tag;
    logic [4:0] rd;
    logic [31:0] alu, data, pc4, rdata;
    logic rw, mw, err;
    logic [1:0] rs;
    logic [2:0] f3;
    int dly;
  } op_t;

  typedef struct {
    logic [4:0] rd;
    logic [31:0] res, bad, addr, wdata;
    logic wr, we;
    logic [3:0] exc, be;
    int stalls, reqs;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic op_t mk(input string tag, input logic [4:0] rd, input logic [31:0] alu, data, pc4,
                             input logic rw, input logic [1:0] rs, input logic mw, input logic [2:0] f3,
                             input int dly, input logic [31:0] rdata, input logic err);
    op_t o;
    o.tag = tag; o.rd = rd; o.alu = alu; o.data = data; o.pc4 = pc4; o.rw = rw; o.rs = rs;
    o.mw = mw; o.f3 = f3; o.dly = dly; o.rdata = rdata; o.err = err;
    return o;
  endfunction

  function automatic exp_t model(input op_t o);
    exp_t e;
    logic mem, ill, mis;
    logic [31:0] raw, mask;
    int sz, off;
    e = '{default: 0};
    e.exc = 4'hF;
    mem = o.mw || o.rs == 2'b01;
    sz = o.f3[1:0] == 2'd0 ? 1 : o.f3[1:0] == 2'd1 ? 2 : 4;
    off = int'(o.alu[1:0]);
    ill = o.f3 == 3'd3 || o.f3 == 3'd6 || o.f3 == 3'd7 || (o.mw && o.f3 >= 3'd4);
    mis = (off % sz) != 0;
    if (!mem) begin
      e.rd = o.rd;
      e.wr = o.rw;
      e.res = o.rs == 2'b10 ? o.pc4 : o.alu;
    end else if (ill || mis) begin
      e.exc = ill ? 4'd2 : o.mw ? 4'd6 : 4'd4;
      e.bad = o.alu;
    end else begin
      e.stalls = o.dly >= TMO ? TMO : o.dly + 1;
      e.reqs = e.stalls;
      e.addr = {o.alu[31:2], 2'b00};
      e.we = o.mw;
      for (int i = 0; i < 4; i++) begin
        e.be[i] = i >= off && i < off + sz;
        e.wdata[8*i+:8] = o.data[8*(i%sz)+:8];
      end
      if (o.err || o.dly >= TMO) begin
        e.exc = o.mw ? 4'd7 : 4'd5;
        e.bad = o.alu;
      end else if (!o.mw) begin
        raw = o.rdata >> (8 * off);
        if (sz < 4) begin
          mask = (32'h1 << (8 * sz)) - 32'h1;
          raw = raw & mask;
          if (!o.f3[2] && raw[8*sz-1]) raw = raw | ~mask;
        end
        e.res = raw;
        e.rd = o.rd;
        e.wr = o.rw;
      end
    end
    return e;
  endfunction

  task automatic nop();
    rd_m = 0; alu_m = 0; data_m = 0; pc4_m = 0; reg_wr_m = 0; rs_m = 0; mem_write_m = 0; f3_m = 0;
  endtask

  task automatic run(input op_t o);
    exp_t e;
    int stalls = 0, reqs = 0, b = 0;
    bit fin = 0;
    logic [3:0] exc_s = 4'hF;
    logic [31:0] bad_s = 0;
    sb.push_back(model(o));
    rd_m = o.rd; alu_m = o.alu; data_m = o.data; pc4_m = o.pc4; reg_wr_m = o.rw;
    rs_m = o.rs; mem_write_m = o.mw; f3_m = o.f3;
    for (int c = 0; c < 200 && !fin; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      if (dmem_req) b++;
      dmem_ready = dmem_req && b > o.dly;
      dmem_rdata = o.rdata;
      dmem_err = o.err;
      @(negedge clk);
      e = sb[0];
      if (dmem_req) begin
        reqs++;
        check({o.tag, "_addr"}, dmem_addr, e.addr);
        check({o.tag, "_we"}, dmem_we, e.we);
        if (o.mw) begin
          check({o.tag, "_be"}, dmem_be, e.be);
          check({o.tag, "_wdata"}, dmem_wdata, e.wdata);
        end
      end
      if (stall) stalls++;
      else begin
        fin = 1;
        exc_s = exc;
        bad_s = bad_addr;
      end
    end
    if (!fin) check({o.tag, "_complete"}, 0, 1);
    @(posedge clk); #1;
    nop();
    dmem_ready = 0;
    e = sb.pop_front();
    check({o.tag, "_rd_w"}, rd_w, e.rd);
    check({o.tag, "_result_w"}, result_w, e.res);
    check({o.tag, "_reg_wr_w"}, reg_wr_w, e.wr);
    check({o.tag, "_exc"}, exc_s, e.exc);
    check({o.tag, "_bad_addr"}, bad_s, e.bad);
    check({o.tag, "_stalls"}, stalls, e.stalls);
    check({o.tag, "_reqs"}, reqs, e.reqs);
  endtask

  initial begin
    nop();
    dmem_ready = 0; dmem_err = 0; dmem_rdata = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req", dmem_req, 0);
    check("rst_we", dmem_we, 0);
    check("rst_be", dmem_be, 0);
    check("rst_stall", stall, 0);
    check("rst_exc", exc, 4'hF);
    check("rst_bad", bad_addr, 0);
    check("rst_rd_w", rd_w, 0);
    check("rst_result_w", result_w, 0);
    check("rst_reg_wr_w", reg_wr_w, 0);
    @(posedge clk); #1;
    rst = 0;
    run(mk("alu", 5'd5, 32'h1111_1111, 0, 32'h0000_1004, 1, 2'b00, 0, 3'd0, 0, 0, 0));
    run(mk("pc4", 5'd6, 32'h0000_00AA, 0, 32'h0000_2004, 1, 2'b10, 0, 3'd0, 0, 0, 0));
    run(mk("sw", 5'd0, 32'h0000_0104, 32'hDEAD_BEEF, 0, 0, 2'b00, 1, 3'd2, 0, 0, 0));
    run(mk("lb", 5'd7, 32'h0000_0203, 0, 0, 1, 2'b01, 0, 3'd0, 0, 32'h80FF_0000, 0));
    run(mk("lbu", 5'd8, 32'h0000_0203, 0, 0, 1, 2'b01, 0, 3'd4, 0, 32'h80FF_0000, 0));
    run(mk("sh_mis", 5'd0, 32'h0000_0301, 32'h0000_1234, 0, 0, 2'b00, 1, 3'd1, 0, 0, 0));
    run(mk("alu2", 5'd9, 32'h0BAD_F00D, 0, 0, 1, 2'b00, 0, 3'd0, 0, 0, 0));
    run(mk("lw_dly", 5'd10, 32'h0000_0400, 0, 0, 1, 2'b01, 0, 3'd2, 3, 32'hCAFE_F00D, 0));
    run(mk("lw_err", 5'd11, 32'h0000_0404, 0, 0, 1, 2'b01, 0, 3'd2, 1, 32'h1234_5678, 1));
    run(mk("sb", 5'd0, 32'h0000_0102, 32'h0000_00A5, 0, 0, 2'b00, 1, 3'd0, 0, 0, 0));
    run(mk("sh", 5'd0, 32'h0000_0302, 32'h0000_1234, 0, 0, 2'b00, 1, 3'd1, 2, 0, 0));
    run(mk("lh", 5'd12, 32'h0000_0402, 0, 0, 1, 2'b01, 0, 3'd1, 0, 32'h8001_7FFF, 0));
    run(mk("lhu", 5'd13, 32'h0000_0400, 0, 0, 1, 2'b01, 0, 3'd5, 1, 32'h8001_7FFF, 0));
    run(mk("ld_ill", 5'd14, 32'h0000_0500, 0, 0, 1, 2'b01, 0, 3'd3, 0, 0, 0));
    run(mk("st_ill", 5'd0, 32'h0000_0500, 32'h55, 0, 0, 2'b00, 1, 3'd4, 0, 0, 0));
    run(mk("lw_mis", 5'd15, 32'h0000_0402, 0, 0, 1, 2'b01, 0, 3'd2, 0, 0, 0));
    run(mk("sw_err", 5'd0, 32'h0000_0600, 32'h0102_0304, 0, 0, 2'b00, 1, 3'd2, 0, 0, 1));
    run(mk("lw_b2b_a", 5'd16, 32'h0000_0700, 0, 0, 1, 2'b01, 0, 3'd2, 0, 32'h1111_2222, 0));
    run(mk("lw_b2b_b", 5'd17, 32'h0000_0704, 0, 0, 1, 2'b01, 0, 3'd2, 0, 32'h3333_4444, 0));
    rd_m = 5'd18; alu_m = 32'h0000_0800; reg_wr_m = 1; rs_m = 2'b01; mem_write_m = 0; f3_m = 3'd2;
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    check("busy_req", dmem_req, 1);
    @(posedge clk); #1;
    rst = 1;
    nop();
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    check("abort_req", dmem_req, 0);
    check("abort_stall", stall, 0);
    check("abort_reg_wr_w", reg_wr_w, 0);
    check("abort_exc", exc, 4'hF);
    @(posedge clk); #1;
`ifdef MEM_STAGE_LSU_TIMEOUT_EN
    run(mk("lw_tmo", 5'd19, 32'h0000_0900, 0, 0, 1, 2'b01, 0, 3'd2, 1000, 0, 0));
`endif
    run(mk("alu_end", 5'd20, 32'h7777_0000, 0, 0, 1, 2'b00, 0, 3'd0, 0, 0, 0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
